// File: rtl/maze_access_arbiter_if.sv
// Requester bus of the maze access arbiter.
// Two requesters share one maze RAM read port. Requester 0 is the VGA renderer and
// requester 1 is the player/collision logic.
//   req0/req1     requester -> arbiter  read request, held until granted
//   addr0/addr1   requester -> arbiter  tile address, stable while req is high
//   gnt0/gnt1     arbiter -> requester  one-cycle grant; the address is taken on that edge
//   rvalid0/1     arbiter -> requester  one-cycle read-data valid, two cycles after the grant
//   rdata         arbiter -> requester  tile bit (1 = wall), qualified by rvalid0/rvalid1
// Modport master is the requester side. Modport slave is the arbiter side.
interface maze_access_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic              rdata;

  modport master (
    output req0, req1, addr0, addr1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport slave (
    input  req0, req1, addr0, addr1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );
endinterface

// File: rtl/maze_access_arbiter.sv
// Maze access arbiter: owns the maze generator's RAM read port.
// It sequences one generation run. That means a gen_start pulse, then a wait for gen_end
// with a timeout. After generation it shares the read port between two requesters with
// strict round-robin alternation, and returns one tile bit per granted read two cycles
// after the grant.
// Ports:
//   clock, reset    system clock; asynchronous active-low reset
//   new_maze        one-cycle request for a new maze; seed_in is sampled on that cycle
//   gen_start       one-cycle pulse to the generator; gen_seed is held stable for it
//   gen_end         generator done level
//   maze_address    registered RAM read address; maze_data is the RAM tile bit
//   maze_ready      high while reads are being arbitrated
//   gen_error       sticky generation timeout flag, cleared by the next new_maze
//   bus             requester bus (maze_access_arbiter_if.slave)
// Optional feature: define ADDR_BOUNDS_CHECK_EN to keep addresses >= WIDTH*HEIGHT away
// from the RAM. Such a read still returns rvalid, with rdata forced to 1 (wall).
module maze_access_arbiter #(
  parameter int WIDTH       = 30,
  parameter int HEIGHT      = 40,
  parameter int ADDR_W      = 11,
  parameter int GEN_TIMEOUT = 4095
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              new_maze,
  input  logic [10:0]       seed_in,
  output logic              gen_start,
  output logic [10:0]       gen_seed,
  input  logic              gen_end,
  output logic [ADDR_W-1:0] maze_address,
  input  logic              maze_data,
  output logic              maze_ready,
  output logic              gen_error,
  maze_access_arbiter_if.slave bus
);

`ifdef ADDR_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(GEN_TIMEOUT + 1);
  localparam int TILES = WIDTH * HEIGHT;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    WAIT,
    READY,
    DRAIN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [10:0]       seed_hold;
  logic              prio1;      // 1: requester 1 wins the next tie
  logic              gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, rdata_q;

  // Two-stage in-flight tag pipe. It runs alongside the one-cycle RAM latency plus the
  // output register, so stage 2 lines up with maze_data for the read being returned.
  logic              tag1_v, tag1_id, tag1_oob;
  logic              tag2_v, tag2_id, tag2_oob;

  logic              pick_v, pick_id, addr_oob, timeout;
  logic [ADDR_W-1:0] addr_sel;

  always_comb begin
    pick_v   = bus.req0 | bus.req1;
    pick_id  = (bus.req0 & bus.req1) ? prio1 : bus.req1;
    addr_sel = pick_id ? bus.addr1 : bus.addr0;
    addr_oob = BOUNDS_EN && (addr_sel >= ADDR_W'(TILES));
    timeout  = (cnt == CNT_W'(GEN_TIMEOUT - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      seed_hold    <= '0;
      prio1        <= 1'b0;
      gen_start    <= 1'b0;
      gen_seed     <= '0;
      maze_address <= '0;
      maze_ready   <= 1'b0;
      gen_error    <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata_q      <= 1'b0;
      tag1_v       <= 1'b0;
      tag1_id      <= 1'b0;
      tag1_oob     <= 1'b0;
      tag2_v       <= 1'b0;
      tag2_id      <= 1'b0;
      tag2_oob     <= 1'b0;
    end else begin
      gen_start <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;

      tag1_v    <= 1'b0;
      tag1_id   <= 1'b0;
      tag1_oob  <= 1'b0;
      tag2_v    <= tag1_v;
      tag2_id   <= tag1_id;
      tag2_oob  <= tag1_oob;
      rvalid0_q <= tag2_v & ~tag2_id;
      rvalid1_q <= tag2_v & tag2_id;
      rdata_q   <= tag2_v & (tag2_oob | maze_data);

      case (state)
        IDLE: begin
          if (new_maze) begin
            state     <= START;
            gen_seed  <= seed_in;
            gen_start <= 1'b1;
            cnt       <= '0;
            gen_error <= 1'b0;
          end
        end
        START: state <= ARM;
        ARM: begin
          if (timeout) begin
            gen_error <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (!gen_end) state <= WAIT;
          end
        end
        WAIT: begin
          if (gen_end) begin
            state      <= READY;
            maze_ready <= 1'b1;
          end else if (timeout) begin
            gen_error <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (new_maze) begin
            state      <= DRAIN;
            maze_ready <= 1'b0;
            seed_hold  <= seed_in;
          end else if (pick_v) begin
            gnt0_q   <= ~pick_id;
            gnt1_q   <= pick_id;
            prio1    <= ~pick_id;
            tag1_v   <= 1'b1;
            tag1_id  <= pick_id;
            tag1_oob <= addr_oob;
            if (!addr_oob) maze_address <= addr_sel;
          end
        end
        DRAIN: begin
          if (!tag1_v && !tag2_v) begin
            state     <= START;
            gen_seed  <= seed_hold;
            gen_start <= 1'b1;
            cnt       <= '0;
            gen_error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = rdata_q;

endmodule
